// File: rtl/key_debounce.sv
// Five-channel push-button debouncer with a fixed-priority press-pulse issuer.
// Each channel: 2-flop synchronizer, stable-level filter, pending bit; one pulse per accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_1kHz,
  input  logic rst_n,
  input  logic btn_7,
  input  logic btn_6,
  input  logic btn_5,
  input  logic btn_4,
  input  logic btn_0,
  output logic btn_7_out,
  output logic btn_6_out,
  output logic btn_5_out,
  output logic btn_4_out,
  output logic btn_0_out,
  output logic btn_busy
);

  localparam int          NCH     = 5;
  localparam logic [7:0]  CNT_MAX = 8'(DEBOUNCE_MS - 1);

  // Channel index order is also priority order: bit 4 (btn_7) highest, bit 0 (btn_0) lowest.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] stable_q, stable_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] press;
  logic [NCH-1:0] issue;
  logic [NCH-1:0] out_q;
  logic           busy_q;
  logic [7:0]     cnt_q [NCH];
  logic [7:0]     cnt_d [NCH];

  assign raw = {btn_7, btn_6, btn_5, btn_4, btn_0};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign press = stable_d & ~stable_q;

  // Ascending scan lets the highest pending channel overwrite lower ones.
  always_comb begin
    issue = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pending_q[i]) begin
        issue = NCH'(1) << i;
      end
    end
  end

  // A press landing on the issue edge re-arms the bit, so set beats clear.
  assign pending_d = (pending_q & ~issue) | press;

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      out_q     <= issue;
      busy_q    <= |pending_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_7_out = out_q[4];
  assign btn_6_out = out_q[3];
  assign btn_5_out = out_q[2];
  assign btn_4_out = out_q[1];
  assign btn_0_out = out_q[0];
  assign btn_busy  = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: table-driven press scenarios with a pulse scoreboard,
// plus hand sequences for bounce, long hold, reset mid-count and parameter extremes.
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_vec;   // {btn_7, btn_6, btn_5, btn_4, btn_0}
  logic [4:0] out_vec;
  logic       busy;

  logic sw_btn5;
  logic sw2_o7, sw2_o6, sw2_o5, sw2_o4, sw2_o0, sw2_busy;
  logic swf_o7, swf_o6, swf_o5, swf_o4, swf_o0, swf_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int sw2_cnt = 0, sw2_cyc = 0;
  int swf_cnt = 0, swf_cyc = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [4:0] mask;
    int         hold;
    bit         pulse;
  } vec_t;
  vec_t tbl[9];

  key_debounce #(.DEBOUNCE_MS(20)) dut (
    .clk_1kHz(clk), .rst_n(rst_n),
    .btn_7(btn_vec[4]), .btn_6(btn_vec[3]), .btn_5(btn_vec[2]),
    .btn_4(btn_vec[1]), .btn_0(btn_vec[0]),
    .btn_7_out(out_vec[4]), .btn_6_out(out_vec[3]), .btn_5_out(out_vec[2]),
    .btn_4_out(out_vec[1]), .btn_0_out(out_vec[0]),
    .btn_busy(busy)
  );

  key_debounce #(.DEBOUNCE_MS(2)) dut_d2 (
    .clk_1kHz(clk), .rst_n(rst_n),
    .btn_7(1'b0), .btn_6(1'b0), .btn_5(sw_btn5), .btn_4(1'b0), .btn_0(1'b0),
    .btn_7_out(sw2_o7), .btn_6_out(sw2_o6), .btn_5_out(sw2_o5),
    .btn_4_out(sw2_o4), .btn_0_out(sw2_o0), .btn_busy(sw2_busy)
  );

  key_debounce #(.DEBOUNCE_MS(255)) dut_d255 (
    .clk_1kHz(clk), .rst_n(rst_n),
    .btn_7(1'b0), .btn_6(1'b0), .btn_5(sw_btn5), .btn_4(1'b0), .btn_0(1'b0),
    .btn_7_out(swf_o7), .btn_6_out(swf_o6), .btn_5_out(swf_o5),
    .btn_4_out(swf_o4), .btn_0_out(swf_o0), .btn_busy(swf_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, actual, required);
    end
  endtask

  // Advance one clock and sample outputs mid-cycle (on the falling edge).
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (out_vec != 5'b0) begin
        check("onehot_outputs", $countones(out_vec), 1);
      end
      if (busy) busy_cnt++;
      for (int i = 0; i < 5; i++) begin
        if (out_vec[i]) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: got pulse on channel %0d, required none", cyc, i);
          end else begin
            e = sb_q.pop_front();
            if (e.ch != i || e.cyc != cyc) begin
              errors++;
              $display("FAIL pulse_order: got channel %0d at cycle %0d, required channel %0d at cycle %0d",
                       i, cyc, e.ch, e.cyc);
            end else begin
              $display("pulse channel %0d at cycle %0d ok", i, cyc);
            end
          end
        end
      end
      if (sw2_o5)  begin sw2_cnt++; sw2_cyc = cyc; end
      if (swf_o5)  begin swf_cnt++; swf_cyc = cyc; end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Leftover scoreboard entries mean a pulse that never arrived within the wait.
  task automatic check_drained(input string name);
    if (sb_q.size() != 0) begin
      $display("FAIL %s_missing: %0d expected pulse(s) still outstanding, first channel %0d at cycle %0d",
               name, sb_q.size(), sb_q[0].ch, sb_q[0].cyc);
      errors++;
      checks++;
      sb_q.delete();
    end else begin
      checks++;
    end
  endtask

  initial begin
    int k0, order, r0;

    tbl[0] = '{mask: 5'b00100, hold: 50, pulse: 1'b1};
    tbl[1] = '{mask: 5'b10011, hold: 40, pulse: 1'b1};
    tbl[2] = '{mask: 5'b11111, hold: 40, pulse: 1'b1};
    tbl[3] = '{mask: 5'b00001, hold: 30, pulse: 1'b1};
    tbl[4] = '{mask: 5'b01000, hold: 25, pulse: 1'b1};
    tbl[5] = '{mask: 5'b00010, hold: 20, pulse: 1'b1};
    tbl[6] = '{mask: 5'b00010, hold: 19, pulse: 1'b0};
    tbl[7] = '{mask: 5'b10000, hold: 5,  pulse: 1'b0};
    tbl[8] = '{mask: 5'b00101, hold: 21, pulse: 1'b1};

    rst_n   = 1'b0;
    btn_vec = 5'b0;
    sw_btn5 = 1'b0;
    steps(3);
    check("reset_outputs", int'(out_vec), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    steps(5);

    // Table scenarios: pulses expected 23 cycles after the driving step, one per cycle in priority order.
    for (int t = 0; t < 9; t++) begin
      k0 = cyc;
      order = 0;
      if (tbl[t].pulse) begin
        for (int ch = 4; ch >= 0; ch--) begin
          if (tbl[t].mask[ch]) begin
            sb_q.push_back('{ch: ch, cyc: k0 + 23 + order});
            order++;
          end
        end
      end
      busy_cnt = 0;
      btn_vec  = tbl[t].mask;
      steps(tbl[t].hold);
      btn_vec = 5'b0;
      steps(60);
      check_drained($sformatf("table%0d", t));
      check($sformatf("table%0d_busy_cycles", t), busy_cnt, order);
      $display("table entry %0d mask=%b hold=%0d done", t, tbl[t].mask, tbl[t].hold);
    end

    // Bounce: btn_7 toggles every 3 cycles for 30 cycles; never stable long enough.
    busy_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      btn_vec[4] = ~btn_vec[4];
      steps(3);
    end
    btn_vec = 5'b0;
    steps(40);
    check_drained("bounce");
    check("bounce_busy_cycles", busy_cnt, 0);

    // Long hold then re-press: exactly two btn_6 pulses.
    k0 = cyc;
    sb_q.push_back('{ch: 3, cyc: k0 + 23});
    btn_vec[3] = 1'b1;
    steps(500);
    btn_vec[3] = 1'b0;
    steps(30);
    k0 = cyc;
    sb_q.push_back('{ch: 3, cyc: k0 + 23});
    btn_vec[3] = 1'b1;
    steps(30);
    btn_vec[3] = 1'b0;
    steps(40);
    check_drained("long_hold");

    // Reset mid-count with btn_4 held: only the post-reset press may pulse.
    btn_vec[1] = 1'b1;
    steps(15);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("in_reset_outputs", int'(out_vec), 0);
      check("in_reset_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    r0 = cyc;
    sb_q.push_back('{ch: 1, cyc: r0 + 23});
    steps(40);
    btn_vec[1] = 1'b0;
    steps(40);
    check_drained("reset_mid");

    // Parameter extremes on btn_5.
    sw2_cnt = 0;
    swf_cnt = 0;
    k0 = cyc;
    sw_btn5 = 1'b1;
    steps(300);
    sw_btn5 = 1'b0;
    steps(30);
    check("d2_pulse_count", sw2_cnt, 1);
    check("d2_pulse_cycle", sw2_cyc, k0 + 5);
    check("d255_pulse_count", swf_cnt, 1);
    check("d255_pulse_cycle", swf_cyc, k0 + 258);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
